demux1_4_reg: RTL
=================

Name: demux1_4_reg

Overview:
- Registered 1-to-4 demultiplexer, the distribution-side counterpart of the 4:1 structural multiplexer.
- Accepts one word per handshake on a single input channel and steers it, by 2-bit address, to one of four output lanes.
- Each output lane has a one-entry holding register with valid/ready flow control.
- Saturating per-lane transfer counters support debug and verification.

Parameters:
- WIDTH, 8, data word width in bits
- CNT_W, 8, width of each per-lane transfer counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word present
- in_ready  output  1  block accepts input this cycle
- in_addr  input  2  destination lane; address1 is the MSB, address0 the LSB
- in_data  input  WIDTH  input word
- out_valid  output  4  per-lane word present; bit i is lane i
- out_ready  input  4  per-lane consumer ready
- out_data  output  4*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
- lane_sel  output  4  one-hot decode of in_addr, gated by in_valid; combinational
- cnt_clr  input  1  synchronous clear of all counters
- cnt_flat  output  4*CNT_W  lane i transfer count at [i*CNT_W +: CNT_W]

Behaviour:
- Reset: asserting rst_n low asynchronously clears all outputs and state.
  - out_valid = 0, out_data = 0, cnt_flat = 0.
  - in_ready reflects the empty lanes, so it is 1 once in reset, subject to the ready equation below.
- lane_sel[i] = in_valid & (in_addr == i). It is pure decode and zero when in_valid = 0.
- Lane state: each lane is EMPTY or FULL, indicated by out_valid[i].
- Output handshake: lane i drains when out_valid[i] & out_ready[i].
- Input handshake:
  - in_ready = !out_valid[a] | out_ready[a], where a = in_addr.
  - The input transfer is in_valid & in_ready.
  - in_ready depends combinationally on in_addr and out_ready. It must not depend on in_valid.
- Input transfer: on the next clock edge out_valid[a] <= 1 and lane a's data <= in_data. Input-to-output latency is 1 cycle.
- Simultaneous drain and fill on the same lane: the lane stays FULL with the new data. This gives full throughput, one word per cycle per lane, with no bubble.
- Drain without fill: out_valid[i] <= 0. out_data[i] holds its last value and is not cleared.
- Other lanes are unaffected by a transfer to lane a. A stalled lane never blocks words addressed to other lanes.
- out_data is stable while out_valid[i] = 1 and out_ready[i] = 0.
- Counters:
  - cnt[i] increments on each output drain of lane i.
  - Saturates at 2^CNT_W - 1; no wrap.
  - cnt_clr has priority over an increment in the same cycle.
- Reset mid-operation: any held words are discarded immediately, with no partial transfer. Counters return to 0.
- X-handling: in_addr and in_data are don't-care when in_valid = 0. No state changes.

Decomposition:
- Shared package demux_pkg holds:
  - lane count constant N_LANES = 4
  - address width ADDR_W = 2
  - function onehot4(addr) returning the 4-bit decode, reused by lane_sel and lane write enables
- Natural sub-module demux_lane:
  - one holding register with valid/ready and its saturating counter
  - inputs: clk, rst_n, wr_en, wr_data, rd_ready, cnt_clr
  - outputs: valid, data, count
  - instantiated four times under a generate loop

Test Plan:
- Reset and idle:
  - Drive rst_n low with all out_ready = 1 and in_valid = 0 -> out_valid = 0000, cnt_flat = 0, lane_sel = 0000.
  - After reset release with in_addr = 2 -> in_ready = 1.
- Routing:
  - Send in_data = 0xA0, 0xA1, 0xA2, 0xA3 to addr 0, 1, 2, 3 on consecutive cycles, all out_ready = 1 -> each lane i shows 0xA0+i with out_valid[i] = 1 exactly one cycle after its input.
  - After all four drain, each count = 1.
- Back-pressure isolation:
  - Set out_ready[1] = 0 and load 0x55 into lane 1. A second word to addr 1 -> in_ready = 0, and lane 1 holds 0x55.
  - Concurrently send 0x66 to addr 3 -> accepted, and lane 3 shows 0x66 next cycle.
- Simultaneous drain and fill:
  - Lane 0 FULL with 0x11 and out_ready[0] = 1; send 0x22 to addr 0 -> in_ready = 1.
  - Next cycle lane 0 = 0x22 and out_valid[0] remains 1; count[0] increments by 1.
- Counter saturation and clear:
  - With CNT_W = 4, stream 20 words to lane 2 -> count[2] = 15.
  - Assert cnt_clr coincident with a drain -> count[2] = 0.
- Async reset mid-transfer:
  - With lanes 0 and 3 FULL, pulse rst_n low between clock edges -> out_valid = 0000 immediately, without waiting for a clock edge, and counters = 0.

Source files
------------

// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared constants and helpers for the registered 1-to-4 demultiplexer.
//   N_LANES  : number of output lanes
//   ADDR_W   : width of the lane address
//   onehot4(): 2-bit address -> 4-bit one-hot lane decode
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam int N_LANES = 4;
    localparam int ADDR_W  = 2;

    // Used both for the exported lane_sel and for the lane write enables, so
    // the two decodes can never disagree.
    function automatic logic [N_LANES-1:0] onehot4(input logic [ADDR_W-1:0] addr);
        return 4'b0001 << addr;
    endfunction

endpackage

// File: rtl/demux_lane.sv
// -----------------------------------------------------------------------------
// demux_lane
// One output lane: a single-entry holding register with valid/ready flow
// control plus a saturating count of words drained from it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : load wr_data this cycle (caller guarantees there is room)
//   wr_data    : word to load
//   rd_ready   : downstream consumer ready
//   cnt_clr    : synchronous counter clear, wins over an increment
//   valid      : lane holds a word
//   data       : held word (kept after drain, cleared only by reset)
//   count      : saturating drain count
// -----------------------------------------------------------------------------
module demux_lane #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    input  logic             cnt_clr,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic drain;
    assign drain = valid & rd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (wr_en) begin
            // A fill overrides a same-cycle drain: the lane stays full with
            // the new word, giving one word per cycle with no bubble.
            valid <= 1'b1;
            data  <= wr_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (cnt_clr) begin
            count <= '0;
        end else if (drain && count != CNT_MAX) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/demux1_4_reg.sv
// -----------------------------------------------------------------------------
// demux1_4_reg
// Registered 1-to-4 demultiplexer. One word per input handshake is steered
// by in_addr into one of four single-entry output lanes.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake
//   in_addr, in_data     : destination lane and word
//   out_valid/out_ready  : per-lane output handshake (bit i = lane i)
//   out_data             : lane i at [i*WIDTH +: WIDTH]
//   lane_sel             : combinational one-hot decode of in_addr, gated by in_valid
//   cnt_clr              : synchronous clear of all lane counters
//   cnt_flat             : lane i drain count at [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module demux1_4_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [WIDTH-1:0]         in_data,
    output logic [N_LANES-1:0]       out_valid,
    input  logic [N_LANES-1:0]       out_ready,
    output logic [N_LANES*WIDTH-1:0] out_data,
    output logic [N_LANES-1:0]       lane_sel,
    input  logic                     cnt_clr,
    output logic [N_LANES*CNT_W-1:0] cnt_flat
);

    logic [N_LANES-1:0]            wr_en;
    logic [N_LANES-1:0][WIDTH-1:0] lane_data;
    logic [N_LANES-1:0][CNT_W-1:0] lane_cnt;

    assign lane_sel = in_valid ? onehot4(in_addr) : '0;

    // Readiness looks only at the addressed lane, so a stalled lane never
    // blocks traffic for the others. Deliberately independent of in_valid.
    assign in_ready = !out_valid[in_addr] | out_ready[in_addr];

    assign wr_en = lane_sel & {N_LANES{in_ready}};

    generate
        for (genvar i = 0; i < N_LANES; i++) begin : g_lane
            demux_lane #(
                .WIDTH (WIDTH),
                .CNT_W (CNT_W)
            ) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .wr_en    (wr_en[i]),
                .wr_data  (in_data),
                .rd_ready (out_ready[i]),
                .cnt_clr  (cnt_clr),
                .valid    (out_valid[i]),
                .data     (lane_data[i]),
                .count    (lane_cnt[i])
            );
        end
    endgenerate

    assign out_data = lane_data;
    assign cnt_flat = lane_cnt;

endmodule
